// File: rtl/gpio_cmd_decoder.sv
// gpio_cmd_decoder
//   Host-side command front end for the 2D convolution datapath. Decodes
//   32-bit GPIO command words (toggle request/acknowledge handshake) into the
//   load / start-of-process / valid / image-length controls for the address
//   FSM, steers pixel data toward the line memories and returns readback
//   pixels plus status on the GPIO output word.
// Ports
//   i_CLK, i_reset   clock, synchronous active-high reset
//   i_gpioData       command: [31:29] opcode, [28] request toggle, low bits payload
//   o_gpioData       status: [31] ack toggle, [30:29] state, [27] sticky error,
//                    [26] registered i_EoP, [NB_DATA-1:0] readback pixel
//   o_load, o_SoP    state levels (LOAD, PROC)
//   o_valid          one-cycle strobe per executed DATA/READ command
//   o_imgLength      registered image length
//   o_pixel          pixel for memory write
//   i_memData        pixel read back from memory, RD_LAT cycles after o_valid
//   i_EoP            end of process from address FSM
//   i_changeBlock    block done from address FSM
//   o_softReset      one-cycle datapath soft reset strobe
module gpio_cmd_decoder #(
    parameter int unsigned NB_GPIO  = 32,
    parameter int unsigned NB_IMAGE = 10,
    parameter int unsigned NB_DATA  = 8,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic                i_CLK,
    input  logic                i_reset,
    input  logic [NB_GPIO-1:0]  i_gpioData,
    output logic [NB_GPIO-1:0]  o_gpioData,
    output logic                o_load,
    output logic                o_SoP,
    output logic                o_valid,
    output logic [NB_IMAGE-1:0] o_imgLength,
    output logic [NB_DATA-1:0]  o_pixel,
    input  logic [NB_DATA-1:0]  i_memData,
    input  logic                i_EoP,
    input  logic                i_changeBlock,
    output logic                o_softReset
);

    localparam int unsigned PL_W    = (NB_IMAGE > NB_DATA) ? NB_IMAGE : NB_DATA;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned TOG_BIT = NB_GPIO - 4;
    localparam int unsigned PAD_W   = NB_GPIO - 6 - NB_DATA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_PROC = 2'b10,
        ST_READ = 2'b11
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP        = 3'b000,
        OP_SET_LEN    = 3'b001,
        OP_LOAD_START = 3'b010,
        OP_DATA       = 3'b011,
        OP_START_PROC = 3'b100,
        OP_READ       = 3'b101,
        OP_SOFT_RST   = 3'b110,
        OP_RSVD       = 3'b111
    } op_e;

    // Registered command word fields
    logic [2:0]          cmd_op_q,   cmd_op_d;
    logic                cmd_tog_q,  cmd_tog_d;
    logic [PL_W-1:0]     cmd_pl_q,   cmd_pl_d;
    logic                prev_tog_q, prev_tog_d;

    // Accepted command, executed the cycle after acceptance
    logic                exec_q,     exec_d;
    op_e                 exec_op_q,  exec_op_d;
    logic [PL_W-1:0]     exec_pl_q,  exec_pl_d;

    state_e              state_q,    state_d;
    logic                load_q,     load_d;
    logic                sop_q,      sop_d;
    logic                valid_q,    valid_d;
    logic [NB_DATA-1:0]  pixel_q,    pixel_d;
    logic [NB_IMAGE-1:0] len_q,      len_d;
    logic                srst_q,     srst_d;
    logic                ack_q,      ack_d;
    logic                err_q,      err_d;
    logic                eop_q,      eop_d;
    logic [NB_DATA-1:0]  rdata_q,    rdata_d;
    logic                rd_pend_q,  rd_pend_d;
    logic [CNT_W-1:0]    rd_cnt_q,   rd_cnt_d;

    logic                req_c;
    logic                read_busy_c;
    logic                cmd_legal_c;
    logic                unused_cmd_bits_c;

    // Reserved command bits between the toggle and the payload
    assign unused_cmd_bits_c = ^i_gpioData[TOG_BIT-1:PL_W];

    assign req_c       = cmd_tog_q != prev_tog_q;
    // A READ occupies the handshake from its execute cycle until its ack
    assign read_busy_c = rd_pend_q ||
                         (exec_q && (exec_op_q == OP_READ) && (state_q == ST_READ));

    // State register
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            cmd_op_q   <= 3'b000;
            cmd_tog_q  <= 1'b0;
            cmd_pl_q   <= '0;
            prev_tog_q <= 1'b0;
            exec_q     <= 1'b0;
            exec_op_q  <= OP_NOP;
            exec_pl_q  <= '0;
            state_q    <= ST_IDLE;
            load_q     <= 1'b0;
            sop_q      <= 1'b0;
            valid_q    <= 1'b0;
            pixel_q    <= '0;
            len_q      <= '0;
            srst_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            eop_q      <= 1'b0;
            rdata_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_cnt_q   <= '0;
        end else begin
            cmd_op_q   <= cmd_op_d;
            cmd_tog_q  <= cmd_tog_d;
            cmd_pl_q   <= cmd_pl_d;
            prev_tog_q <= prev_tog_d;
            exec_q     <= exec_d;
            exec_op_q  <= exec_op_d;
            exec_pl_q  <= exec_pl_d;
            state_q    <= state_d;
            load_q     <= load_d;
            sop_q      <= sop_d;
            valid_q    <= valid_d;
            pixel_q    <= pixel_d;
            len_q      <= len_d;
            srst_q     <= srst_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            eop_q      <= eop_d;
            rdata_q    <= rdata_d;
            rd_pend_q  <= rd_pend_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        cmd_op_d    = i_gpioData[NB_GPIO-1:NB_GPIO-3];
        cmd_tog_d   = i_gpioData[TOG_BIT];
        cmd_pl_d    = i_gpioData[PL_W-1:0];
        prev_tog_d  = prev_tog_q;
        exec_d      = 1'b0;
        exec_op_d   = exec_op_q;
        exec_pl_d   = exec_pl_q;
        state_d     = state_q;
        valid_d     = 1'b0;
        pixel_d     = pixel_q;
        len_d       = len_q;
        srst_d      = 1'b0;
        ack_d       = ack_q;
        err_d       = err_q;
        eop_d       = i_EoP;
        rdata_d     = rdata_q;
        rd_pend_d   = rd_pend_q;
        rd_cnt_d    = rd_cnt_q;
        cmd_legal_c = 1'b0;

        // Accept a request, or reject it (without consuming the toggle) during a READ
        if (req_c) begin
            if (read_busy_c) begin
                err_d = 1'b1;
            end else begin
                prev_tog_d = cmd_tog_q;
                exec_d     = 1'b1;
                exec_op_d  = op_e'(cmd_op_q);
                exec_pl_d  = cmd_pl_q;
            end
        end

        // Handshake-driven state transitions from the address FSM
        unique case (state_q)
            ST_LOAD: if (i_changeBlock)            state_d = ST_IDLE;
            ST_PROC: if (i_EoP)                    state_d = ST_READ;
            ST_READ: if (i_changeBlock && !i_EoP)  state_d = ST_IDLE;
            default: ;
        endcase

        // Readback capture and deferred ack for READ
        if (rd_pend_q) begin
            if (rd_cnt_q == CNT_W'(1)) begin
                rdata_d   = i_memData;
                ack_d     = ~ack_q;
                rd_pend_d = 1'b0;
            end
            rd_cnt_d = rd_cnt_q - CNT_W'(1);
        end

        // Command execution
        if (exec_q) begin
            unique case (exec_op_q)
                OP_NOP: cmd_legal_c = 1'b1;
                OP_SET_LEN: begin
                    if (state_q == ST_IDLE) begin
                        cmd_legal_c = 1'b1;
                        len_d       = exec_pl_q[NB_IMAGE-1:0];
                    end
                end
                OP_LOAD_START: begin
                    if (state_q == ST_IDLE) begin
                        cmd_legal_c = 1'b1;
                        state_d     = ST_LOAD;
                    end
                end
                OP_DATA: begin
                    if (state_q == ST_LOAD) begin
                        cmd_legal_c = 1'b1;
                        pixel_d     = exec_pl_q[NB_DATA-1:0];
                        valid_d     = 1'b1;
                    end
                end
                OP_START_PROC: begin
                    if (state_q == ST_IDLE) begin
                        cmd_legal_c = 1'b1;
                        state_d     = ST_PROC;
                    end
                end
                OP_READ: begin
                    if (state_q == ST_READ) begin
                        cmd_legal_c = 1'b1;
                        valid_d     = 1'b1;
                        rd_pend_d   = 1'b1;
                        rd_cnt_d    = CNT_W'(RD_LAT);
                    end
                end
                OP_SOFT_RST: begin
                    cmd_legal_c = 1'b1;
                    srst_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
                OP_RSVD: ;
                default: ;
            endcase
            if (!cmd_legal_c) begin
                err_d = 1'b1;
            end
            if (exec_op_q == OP_SOFT_RST) begin
                err_d = 1'b0;
            end
            // A legal READ acks when its data arrives instead
            if (!((exec_op_q == OP_READ) && cmd_legal_c)) begin
                ack_d = ~ack_q;
            end
        end

        load_d = (state_d == ST_LOAD);
        sop_d  = (state_d == ST_PROC);
    end

    assign o_gpioData  = {ack_q, state_q, 1'b0, err_q, eop_q, {PAD_W{1'b0}}, rdata_q};
    assign o_load      = load_q;
    assign o_SoP       = sop_q;
    assign o_valid     = valid_q;
    assign o_imgLength = len_q;
    assign o_pixel     = pixel_q;
    assign o_softReset = srst_q;

endmodule
